max_pool_2x2: RTL and testbench
===============================

Name: max_pool_2x2

Overview:
- Downstream neighbour of the channel accumulator.
- Consumes its saturated int8 conv results, which arrive in 2x2 window order: 4 consecutive valid beats per window, windows in raster order.
- Emits one max-pooled (optionally ReLU'd) int8 value per window, with a sequential output address, for write into the next layer's ifmap buffer.
- No backpressure: must accept a beat every cycle.

Parameters:
DATA_W, 8, signed data width of input and output samples
SIZE_W, 8, width of ofmap_size_i (ofmap side length)
ADDR_W, 10, width of pool_addr_o
RELU_EN, 1, 1 = clamp pooled result to >= 0; 0 = pass signed max

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cfg_valid_i  input  1  start pulse; latches ofmap_size_i
ofmap_size_i  input  SIZE_W  conv ofmap side length (e.g. 28), must be even and >= 2
conv_valid_i  input  1  input beat valid
conv_result_i  input  DATA_W  signed conv result
last_i  input  1  marks final conv beat of the layer
pool_valid_o  output  1  pooled result valid (one-cycle pulse per window)
pool_data_o  output  DATA_W  pooled signed result
pool_addr_o  output  ADDR_W  pooled output address, 0..(S/2)^2-1
pool_last_o  output  1  high with final window's pool_valid_o
busy_o  output  1  high in RUN
err_o  output  1  sticky protocol error flag

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst sampled on posedge clk).
- Reset values: all outputs 0; state IDLE; beat count 0; window count 0; running max = -2^(DATA_W-1).
- States: IDLE, RUN.
- IDLE + cfg_valid_i:
  - S = ofmap_size_i; total = (S>>1)*(S>>1).
  - err_o cleared; window count and beat count zeroed.
  - If S is odd or S < 2: err_o <= 1, stay IDLE. Otherwise -> RUN.
- IDLE + conv_valid_i: beat dropped, err_o <= 1.
- RUN, beat accepted on a posedge with conv_valid_i=1:
  - beat 0: running max = input.
  - beats 1-2: running max = signed max(running, input).
  - beat 3 (window close): m = signed max(running, input); m = max(m,0) if RELU_EN.
    - Next cycle: pool_valid_o=1, pool_data_o=m, pool_addr_o=window count. Latency is exactly 1 cycle after the 4th beat.
    - Window count increments and beat count resets to 0.
    - If window count == total-1: pool_last_o=1 with that pulse, then -> IDLE.
- Gaps (conv_valid_i=0) between beats in RUN are allowed; partial window state is held.
- Back-to-back windows with no gaps yield pool_valid_o every 4th cycle.
- pool_data_o and pool_addr_o hold their value between pulses. pool_valid_o and pool_last_o are single-cycle.
- last_i check: asserted on a beat that is not beat 3 of window total-1, or deasserted on that beat -> err_o <= 1. Pooling is still driven purely by counts, not by last_i.
- cfg_valid_i in RUN: ignored, err_o <= 1.
- busy_o = (state == RUN).
- err_o is sticky until the next accepted cfg_valid_i or rst.
- rst mid-window or mid-layer: partial window is discarded, no output pulse, all state returns to reset values next cycle.
- Signed compare throughout. Ties keep either value (identical).
- No arithmetic widening needed; output width equals input width.

Test Plan:
- Config S=4 (total=4); 16 beats with no gaps. Window 0 = {-5, 3, 7, -128}, window 3 = {-1, -2, -3, -4}, RELU_EN=1 -> pool_data 7 @addr0 and 0 @addr3; pool_last_o only on addr3; busy_o drops the cycle after; err_o=0.
- Same stream with RELU_EN=0 -> addr3 = -1. Window {-128 x4} -> -128.
- S=28 with random int8 beats and random 0-4 cycle gaps -> 196 pulses, addresses 0..195 in order, each equal to a golden max(+ReLU) of its 4 beats; exactly one pool_last_o.
- Protocol errors:
  - last_i asserted on beat 2 of window 0 -> err_o=1, pooling continues correctly.
  - cfg_valid_i with S=5 -> err_o=1, stays IDLE.
  - conv_valid_i in IDLE -> err_o=1, no output.
- Assert rst after 2 beats of window 1 (S=4) -> no pulse. Re-config, then 16 beats -> addresses restart at 0 with correct maxima.
- Checks at window 0 beat 3 with S=2 (total=1): output 1 cycle later, pool_valid_o and pool_last_o high together, state IDLE the following cycle.

Source files
------------

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: reduces each 2x2 window of int8 conv results (4 consecutive
// valid beats, windows in raster order) to one max-pooled value, optionally
// ReLU-clamped, with a sequential output address for the next layer's ifmap.
module max_pool_2x2 #(
    parameter int DATA_W  = 8,
    parameter int SIZE_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int RELU_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid_i,
    input  logic [SIZE_W-1:0] ofmap_size_i,
    input  logic              conv_valid_i,
    input  logic [DATA_W-1:0] conv_result_i,
    input  logic              last_i,
    output logic              pool_valid_o,
    output logic [DATA_W-1:0] pool_data_o,
    output logic [ADDR_W-1:0] pool_addr_o,
    output logic              pool_last_o,
    output logic              busy_o,
    output logic              err_o
);

    // Window counter is wide enough to hold (S/2)^2 for any S that fits SIZE_W.
    localparam int CNT_W = 2 * SIZE_W;
    localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]               beat_cnt;
    logic [CNT_W-1:0]         win_cnt;
    logic [CNT_W-1:0]         last_win;
    logic signed [DATA_W-1:0] run_max;
    logic signed [DATA_W-1:0] in_data;
    logic signed [DATA_W-1:0] max_cur;
    logic signed [DATA_W-1:0] pooled;
    logic [SIZE_W-1:0]        half_size;
    logic [CNT_W-1:0]         total_cfg;
    logic                     cfg_bad;
    logic                     on_last_window;
    logic                     last_expected;
    logic                     layer_end;

    assign in_data        = $signed(conv_result_i);
    assign max_cur        = (in_data > run_max) ? in_data : run_max;
    assign half_size      = ofmap_size_i >> 1;
    assign total_cfg      = CNT_W'(half_size) * CNT_W'(half_size);
    assign cfg_bad        = ofmap_size_i[0] | (ofmap_size_i < SIZE_W'(2));
    assign on_last_window = (win_cnt == last_win);
    assign last_expected  = (beat_cnt == 2'd3) && on_last_window;
    assign layer_end      = (state == RUN) && conv_valid_i && last_expected;
    assign busy_o         = (state == RUN);

    // Window-close result: signed max of the window, clamped at zero when ReLU is enabled.
    always_comb begin
        pooled = max_cur;
        if ((RELU_EN != 0) && max_cur[DATA_W-1]) begin
            pooled = '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a legal config starts a layer; the last beat of the last window ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cfg_valid_i && !cfg_bad) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (layer_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: running max, beat/window counters, output register and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt     <= '0;
            win_cnt      <= '0;
            last_win     <= '0;
            run_max      <= MIN_VAL;
            pool_valid_o <= 1'b0;
            pool_data_o  <= '0;
            pool_addr_o  <= '0;
            pool_last_o  <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            pool_valid_o <= 1'b0;
            pool_last_o  <= 1'b0;
            if (state == IDLE) begin
                if (cfg_valid_i) begin
                    last_win <= total_cfg - CNT_W'(1);
                    win_cnt  <= '0;
                    beat_cnt <= '0;
                    run_max  <= MIN_VAL;
                    err_o    <= cfg_bad;
                end
                if (conv_valid_i) begin
                    err_o <= 1'b1;
                end
            end else begin
                if (cfg_valid_i) begin
                    err_o <= 1'b1;
                end
                if (conv_valid_i) begin
                    if (last_i != last_expected) begin
                        err_o <= 1'b1;
                    end
                    if (beat_cnt == 2'd3) begin
                        pool_valid_o <= 1'b1;
                        pool_data_o  <= pooled;
                        pool_addr_o  <= ADDR_W'(win_cnt);
                        pool_last_o  <= on_last_window;
                        win_cnt      <= win_cnt + CNT_W'(1);
                        beat_cnt     <= '0;
                        run_max      <= MIN_VAL;
                    end else begin
                        beat_cnt <= beat_cnt + 2'd1;
                        run_max  <= (beat_cnt == 2'd0) ? in_data : max_cur;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: drives a ReLU and a non-ReLU instance with the same stream
// and compares every cycle against a window-level reference model.
module tb_max_pool_2x2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic [7:0]        ofmap_size;
    logic              conv_valid;
    logic [7:0]        conv_result;
    logic              last;

    logic              r_valid, r_last, r_busy, r_err;
    logic signed [7:0] r_data;
    logic [9:0]        r_addr;
    logic              n_valid, n_last, n_busy, n_err;
    logic signed [7:0] n_data;
    logic [9:0]        n_addr;

    int n_assert = 0;
    int n_fail   = 0;
    int pulse_cnt;
    int last_cnt;

    // Reference model state: layer running flag, window index, size, sticky error,
    // beats of the current window, and the expected held outputs.
    bit m_run;
    int m_total;
    int m_win;
    bit m_err;
    int q[$];
    bit exp_valid;
    bit exp_last;
    int exp_addr;
    int exp_relu;
    int exp_raw;

    max_pool_2x2 #(.RELU_EN(1)) u_relu (
        .clk(clk), .rst(rst), .cfg_valid_i(cfg_valid), .ofmap_size_i(ofmap_size),
        .conv_valid_i(conv_valid), .conv_result_i(conv_result), .last_i(last),
        .pool_valid_o(r_valid), .pool_data_o(r_data), .pool_addr_o(r_addr),
        .pool_last_o(r_last), .busy_o(r_busy), .err_o(r_err)
    );

    max_pool_2x2 #(.RELU_EN(0)) u_raw (
        .clk(clk), .rst(rst), .cfg_valid_i(cfg_valid), .ofmap_size_i(ofmap_size),
        .conv_valid_i(conv_valid), .conv_result_i(conv_result), .last_i(last),
        .pool_valid_o(n_valid), .pool_data_o(n_data), .pool_addr_o(n_addr),
        .pool_last_o(n_last), .busy_o(n_busy), .err_o(n_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Applies one clock cycle of inputs to the model: what a layer of 2x2 windows should produce.
    task automatic modelStep(input bit r, input bit c, input int sz, input bit v, input int d, input bit l);
        int mx;
        bit final_beat;
        exp_valid = 0;
        exp_last  = 0;
        if (r) begin
            m_run = 0; m_total = 0; m_win = 0; m_err = 0; q.delete();
            exp_addr = 0; exp_relu = 0; exp_raw = 0;
            return;
        end
        if (!m_run) begin
            if (c) begin
                m_err   = (sz % 2 == 1) || (sz < 2);
                m_total = (sz / 2) * (sz / 2);
                m_win   = 0;
                q.delete();
                m_run   = !m_err;
            end
            if (v) m_err = 1;
        end else begin
            if (c) m_err = 1;
            if (v) begin
                q.push_back(d);
                final_beat = (q.size() == 4) && (m_win == m_total - 1);
                if (l != final_beat) m_err = 1;
                if (q.size() == 4) begin
                    mx = q[0];
                    foreach (q[i]) if (q[i] > mx) mx = q[i];
                    exp_valid = 1;
                    exp_last  = final_beat;
                    exp_addr  = m_win;
                    exp_raw   = mx;
                    exp_relu  = (mx < 0) ? 0 : mx;
                    m_win++;
                    q.delete();
                    if (final_beat) m_run = 0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        chk("relu.valid", r_valid, exp_valid);
        chk("relu.last",  r_last,  exp_last);
        chk("relu.data",  r_data,  exp_relu);
        chk("relu.addr",  r_addr,  exp_addr);
        chk("relu.busy",  r_busy,  m_run);
        chk("relu.err",   r_err,   m_err);
        chk("raw.valid",  n_valid, exp_valid);
        chk("raw.last",   n_last,  exp_last);
        chk("raw.data",   n_data,  exp_raw);
        chk("raw.addr",   n_addr,  exp_addr);
        chk("raw.busy",   n_busy,  m_run);
        chk("raw.err",    n_err,   m_err);
        if (r_valid === 1'b1) pulse_cnt++;
        if (r_last === 1'b1) last_cnt++;
    endtask

    // One cycle: drive inputs, clock, then compare the registered outputs against the model.
    task automatic applyStimulus(input bit r, input bit c, input int sz, input bit v, input int d, input bit l);
        rst = r; cfg_valid = c; ofmap_size = 8'(sz);
        conv_valid = v; conv_result = 8'(d); last = l;
        @(posedge clk);
        #1;
        modelStep(r, c, sz, v, d, l);
        checkOutput();
        rst = 0; cfg_valid = 0; conv_valid = 0; last = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int sz);
        applyStimulus(0, 1, sz, 0, 0, 0);
    endtask

    task automatic beat(input int d, input bit l);
        applyStimulus(0, 0, 0, 1, d, l);
    endtask

    int s4_stream[16] = '{-5, 3, 7, -128,  10, 20, -30, 5,  -100, -50, -60, -70,  -1, -2, -3, -4};

    initial begin
        rst = 0; cfg_valid = 0; ofmap_size = 0; conv_valid = 0; conv_result = 0; last = 0;
        $display("[TB] reset");
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);

        $display("[TB] S=4 gap-free layer");
        pulse_cnt = 0; last_cnt = 0;
        cfg(4);
        for (int i = 0; i < 16; i++) beat(s4_stream[i], i == 15);
        idle(2);
        chk("s4.pulses", pulse_cnt, 4);
        chk("s4.lasts", last_cnt, 1);

        $display("[TB] S=2 single window of -128");
        cfg(2);
        for (int i = 0; i < 4; i++) beat(-128, i == 3);
        idle(1);

        $display("[TB] beat while idle");
        beat(42, 0);
        idle(1);

        $display("[TB] odd size config");
        cfg(4);
        idle(1);
        applyStimulus(1, 0, 0, 0, 0, 0);
        cfg(5);
        idle(2);

        $display("[TB] S=28 random with gaps");
        pulse_cnt = 0; last_cnt = 0;
        cfg(28);
        for (int w = 0; w < 196; w++) begin
            for (int b = 0; b < 4; b++) begin
                idle($urandom_range(0, 4));
                beat(int'($signed(8'($urandom))), (w == 195) && (b == 3));
            end
        end
        idle(2);
        chk("s28.pulses", pulse_cnt, 196);
        chk("s28.lasts", last_cnt, 1);

        $display("[TB] early last_i and cfg during run");
        cfg(4);
        beat(-9, 0); beat(4, 0); beat(2, 1); beat(-3, 0);
        cfg(2);
        for (int i = 4; i < 16; i++) beat(s4_stream[i], i == 15);
        idle(2);

        $display("[TB] reset mid-layer then restart");
        cfg(4);
        for (int i = 0; i < 6; i++) beat(s4_stream[i], 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        idle(2);
        pulse_cnt = 0; last_cnt = 0;
        cfg(4);
        for (int i = 0; i < 16; i++) beat(s4_stream[15 - i], i == 15);
        idle(2);
        chk("restart.pulses", pulse_cnt, 4);
        chk("restart.lasts", last_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
